// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: conditions the raw line, frames bytes and resolves set-2 E0/F0 prefixes.
// Optional parity enforcement is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_key_decoder #(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned TIMEOUT_US = 200,
   parameter int unsigned FILTER_LEN = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       pressed,
   output logic [7:0] code,
   output logic       extended,
   output logic       key_valid,
   output logic       frame_err
);

   localparam int unsigned ToLimit = CLK_HZ / 1_000_000 * TIMEOUT_US;
   localparam int unsigned ToW     = $clog2(ToLimit) + 1;
   localparam int unsigned FcW     = $clog2(FILTER_LEN) + 1;

   typedef enum logic [2:0] {StIdle, StRecv, StParity, StStop, StDecode} state_e;

   logic           clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
   logic           filt_q, filt_d;
   logic [FcW-1:0] fcnt_q, fcnt_d;
   logic           fall;

   state_e         state_q, state_d;
   logic [2:0]     bitcnt_q, bitcnt_d;
   logic [7:0]     sr_q, sr_d;
   logic           ext_q, ext_d, brk_q, brk_d;
   logic [ToW-1:0] tcnt_q, tcnt_d;
   logic           pressed_q, pressed_d, extended_q, extended_d, key_valid_q, key_valid_d;
   logic [7:0]     code_q, code_d;
   logic           accept;
`ifdef PS2_PARITY_CHECK_EN
   logic           par_q, par_d;
`endif

   // Keyboard status/ack bytes that carry no key meaning when no prefix is pending.
   function automatic logic is_ctrl(input logic [7:0] b);
      return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) || (b == 8'hEE) ||
             (b == 8'h00) || (b == 8'hFF);
   endfunction

   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      if (clk_sync_q != filt_q) begin
         if (fcnt_q == FcW'(FILTER_LEN - 1)) filt_d = clk_sync_q;
         else                                fcnt_d = fcnt_q + 1'b1;
      end
   end

   assign fall = filt_q & ~filt_d;

   always_comb begin
      state_d     = state_q;
      bitcnt_d    = bitcnt_q;
      sr_d        = sr_q;
      ext_d       = ext_q;
      brk_d       = brk_q;
      tcnt_d      = '0;
      pressed_d   = pressed_q;
      code_d      = code_q;
      extended_d  = extended_q;
      key_valid_d = 1'b0;
      frame_err   = 1'b0;
      accept      = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_d       = par_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (fall && !data_sync_q) begin
               state_d  = StRecv;
               bitcnt_d = '0;
               sr_d     = '0;
            end
         end
         StRecv: begin
            if (fall) begin
               sr_d     = {data_sync_q, sr_q[7:1]};
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) state_d = StParity;
            end
         end
         StParity: begin
            if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
               par_d = data_sync_q;
`endif
               state_d = StStop;
            end
         end
         StStop: begin
            if (fall) begin
               if (!data_sync_q) begin
                  frame_err = 1'b1;
                  state_d   = StIdle;
                  sr_d      = '0;
`ifdef PS2_PARITY_CHECK_EN
               end else if (^{sr_q, par_q} != 1'b1) begin
                  frame_err = 1'b1;
                  state_d   = StIdle;
                  sr_d      = '0;
`endif
               end else begin
                  accept  = 1'b1;
                  state_d = StDecode;
               end
            end
         end
         StDecode: state_d = StIdle;
         default:  state_d = StIdle;
      endcase

      // Edge has priority: a fall in the same cycle as the limit restarts the count.
      if (state_q inside {StRecv, StParity, StStop} && !fall) begin
         if (tcnt_q == ToW'(ToLimit - 1)) begin
            frame_err = 1'b1;
            state_d   = StIdle;
            sr_d      = '0;
         end else begin
            tcnt_d = tcnt_q + 1'b1;
         end
      end

      // Decode is registered on entry to StDecode so key_valid shows during that cycle.
      if (accept) begin
         if (sr_q == 8'hE0) begin
            ext_d = 1'b1;
         end else if (sr_q == 8'hF0) begin
            brk_d = 1'b1;
         end else if (!(is_ctrl(sr_q) && !ext_q && !brk_q)) begin
            code_d      = sr_q;
            pressed_d   = ~brk_q;
            extended_d  = ext_q;
            key_valid_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_meta_q  <= 1'b1;
         clk_sync_q  <= 1'b1;
         data_meta_q <= 1'b1;
         data_sync_q <= 1'b1;
         filt_q      <= 1'b1;
         fcnt_q      <= '0;
         state_q     <= StIdle;
         bitcnt_q    <= '0;
         sr_q        <= '0;
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         tcnt_q      <= '0;
         pressed_q   <= 1'b0;
         code_q      <= 8'h00;
         extended_q  <= 1'b0;
         key_valid_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         par_q       <= 1'b0;
`endif
      end else begin
         clk_meta_q  <= ps2_clk;
         clk_sync_q  <= clk_meta_q;
         data_meta_q <= ps2_data;
         data_sync_q <= data_meta_q;
         filt_q      <= filt_d;
         fcnt_q      <= fcnt_d;
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         sr_q        <= sr_d;
         ext_q       <= ext_d;
         brk_q       <= brk_d;
         tcnt_q      <= tcnt_d;
         pressed_q   <= pressed_d;
         code_q      <= code_d;
         extended_q  <= extended_d;
         key_valid_q <= key_valid_d;
`ifdef PS2_PARITY_CHECK_EN
         par_q       <= par_d;
`endif
      end
   end

   assign pressed   = pressed_q;
   assign code      = code_q;
   assign extended  = extended_q;
   assign key_valid = key_valid_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scenarios plus random frames checked against a
// prefix-tracking reference model of the key protocol.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

   localparam int unsigned FL    = 8;
   localparam int unsigned TO_US = 200;
   localparam int unsigned H     = 20;  // PS/2 half-bit time in system clocks

   logic       clk = 1'b0;
   logic       reset, ps2_clk, ps2_data;
   logic       pressed, extended, key_valid, frame_err;
   logic [7:0] code;

   int n_vec = 0, n_err = 0;
   int cyc = 0, kv_cnt = 0, fe_cnt = 0, kv_cyc = 0, fall_cyc = 0;
   logic [7:0] obs_code;
   logic       obs_pressed, obs_ext;
   bit         m_ext = 0, m_brk = 0;
   bit         par_chk;

   always #10 clk = ~clk;

   ps2_key_decoder #(
      .CLK_HZ    (50_000_000),
      .TIMEOUT_US(TO_US),
      .FILTER_LEN(FL)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .pressed  (pressed),
      .code     (code),
      .extended (extended),
      .key_valid(key_valid),
      .frame_err(frame_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (key_valid === 1'b1) begin
         kv_cnt++;
         kv_cyc      = cyc;
         obs_code    = code;
         obs_pressed = pressed;
         obs_ext     = extended;
      end
      if (frame_err === 1'b1) fe_cnt++;
      if (key_valid === 1'b1 || frame_err === 1'b1)
         check("exclusive", {31'd0, key_valid & frame_err}, 32'd0);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ps2_bit(input bit b);
      ps2_data = b;
      tick(H);
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      tick(H);
      ps2_clk  = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      m_ext = 0;
      m_brk = 0;
   endtask

   // Sends one frame, predicts the outcome from the protocol rules, and compares.
   task automatic frame(input string tag, input logic [7:0] b, input bit bad_par,
                        input bit bad_stop);
      int  kv0, fe0;
      bit  e_kv, e_fe, e_pr, e_ex;
      kv0 = kv_cnt;
      fe0 = fe_cnt;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit((~^b) ^ bad_par);
      ps2_bit(~bad_stop);
      ps2_data = 1'b1;
      tick(FL + 12);

      e_kv = 0; e_fe = 0; e_pr = 0; e_ex = 0;
      if (bad_stop || (par_chk && bad_par)) e_fe = 1;
      else if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if ((b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) && !m_ext && !m_brk) e_kv = 0;
      else begin
         e_kv = 1; e_pr = !m_brk; e_ex = m_ext;
         m_ext = 0; m_brk = 0;
      end

      check({tag, ".kv"}, kv_cnt - kv0, {31'd0, e_kv});
      check({tag, ".fe"}, fe_cnt - fe0, {31'd0, e_fe});
      if (e_kv && kv_cnt - kv0 == 1) begin
         check({tag, ".code"}, {24'd0, obs_code}, {24'd0, b});
         check({tag, ".pressed"}, {31'd0, obs_pressed}, {31'd0, e_pr});
         check({tag, ".ext"}, {31'd0, obs_ext}, {31'd0, e_ex});
         check({tag, ".lat"}, ((kv_cyc - fall_cyc) >= FL + 2 && (kv_cyc - fall_cyc) <= FL + 3),
               32'd1);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".kv"}, {31'd0, key_valid}, 32'd0);
      check({tag, ".fe"}, {31'd0, frame_err}, 32'd0);
      check({tag, ".code"}, {24'd0, code}, 32'd0);
      check({tag, ".pressed"}, {31'd0, pressed}, 32'd0);
      check({tag, ".ext"}, {31'd0, extended}, 32'd0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int kv0, fe0, r;
      logic [7:0] b;
`ifdef PS2_PARITY_CHECK_EN
      par_chk = 1;
`else
      par_chk = 0;
`endif
      reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      tick(5);
      reset = 1'b0;
      check_zero("reset");

      frame("t1_make", 8'h1C, 0, 0);
      frame("t2_f0", 8'hF0, 0, 0);
      frame("t2_brk", 8'h1C, 0, 0);
      frame("t3_e0", 8'hE0, 0, 0);
      frame("t3_f0", 8'hF0, 0, 0);
      frame("t3_key", 8'h75, 0, 0);
      frame("t3_next", 8'h1C, 0, 0);
      frame("ack", 8'hFA, 0, 0);

      // Truncated frame left idle past the timeout.
      kv0 = kv_cnt;
      fe0 = fe_cnt;
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(i[0]);
      ps2_data = 1'b1;
      tick((TO_US + 10) * 50);
      check("t4_timeout.fe", fe_cnt - fe0, 32'd1);
      check("t4_timeout.kv", kv_cnt - kv0, 32'd0);
      frame("t4_after", 8'h15, 0, 0);

      frame("t5_stop", 8'h1D, 0, 1);
      frame("t5_par", 8'h1D, 1, 0);

      // Reset after six bits of a 0x24 frame.
      ps2_bit(1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(r[0] ^ r[0] ^ ((8'h24 >> i) & 1));
      ps2_data = 1'b1;
      tick(3);
      do_reset();
      check_zero("t6_reset");
      frame("t6_fresh", 8'h24, 0, 0);

      // Short low glitch on ps2_clk with data low must not start a frame.
      kv0 = kv_cnt;
      fe0 = fe_cnt;
      ps2_data = 1'b0;
      ps2_clk  = 1'b0;
      tick(FL - 3);
      ps2_clk = 1'b1;
      tick(30);
      ps2_data = 1'b1;
      tick(10);
      check("glitch.kv", kv_cnt - kv0, 32'd0);
      check("glitch.fe", fe_cnt - fe0, 32'd0);
      frame("glitch_after", 8'h24, 0, 0);

      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 9);
         if (r < 2)      b = 8'hE0;
         else if (r < 4) b = 8'hF0;
         else            b = 8'($urandom_range(0, 255));
         frame("rand", b, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
